// File: rtl/pipe_avg_if.sv
// Handshake and data bundle for pipe_avg: sample side (in_*) and result side (out_*).
interface pipe_avg_if #(
   parameter int unsigned DATAWIDTH = 16,
   parameter int unsigned NUM_IN    = 8,
   parameter int unsigned SAW       = 8
);
   localparam int unsigned L  = $clog2(NUM_IN);
   localparam int unsigned SW = DATAWIDTH + L;

   logic                        in_valid;
   logic                        in_ready;
   logic [NUM_IN*DATAWIDTH-1:0] in_data;
   logic [SAW-1:0]              sa;
   logic                        mode;
   logic                        rnd;
   logic                        out_valid;
   logic                        out_ready;
   logic [DATAWIDTH-1:0]        avg;
   logic [SW-1:0]               sum;
   logic                        sat;

   modport master (
      output in_valid, in_data, sa, mode, rnd, out_ready,
      input  in_ready, out_valid, avg, sum, sat
   );

   modport slave (
      input  in_valid, in_data, sa, mode, rnd, out_ready,
      output in_ready, out_valid, avg, sum, sat
   );
endinterface

// File: rtl/pipe_avg.sv
// Pipelined NUM_IN-channel adder tree followed by a registered round/shift/saturate stage.
// One global enable stalls every stage when a held result is not being taken.
module pipe_avg #(
   parameter int unsigned DATAWIDTH = 16,
   parameter int unsigned NUM_IN    = 8,
   parameter int unsigned SAW       = 8
) (
   input  logic      Clk,
   input  logic      Rst,
   pipe_avg_if.slave bus
);
   localparam int unsigned L  = $clog2(NUM_IN);
   localparam int unsigned SW = DATAWIDTH + L;
   localparam logic [SW:0] ONE = 1;

   logic                 en;
   logic [SW-1:0]        tree_q [L][NUM_IN/2];
   logic [SW-1:0]        tree_d [L][NUM_IN/2];
   logic [L-1:0]         v_q, v_d;
   logic [L-1:0]         mode_q, mode_d;
   logic [L-1:0]         rnd_q, rnd_d;
   logic [SAW-1:0]       sa_q [L];
   logic [SAW-1:0]       sa_d [L];

   logic                 out_valid_q, out_valid_d;
   logic [DATAWIDTH-1:0] avg_q, avg_d;
   logic [SW-1:0]        sum_q, sum_d;
   logic                 sat_q, sat_d;

   int unsigned          shift_amt;
   logic [SW:0]          ext, rc, shifted;

   assign en            = ~(out_valid_q & ~bus.out_ready);
   assign bus.in_ready  = en;
   assign bus.out_valid = out_valid_q;
   assign bus.avg       = avg_q;
   assign bus.sum       = sum_q;
   assign bus.sat       = sat_q;

   // Level lv holds NUM_IN >> (lv+1) partial sums; unused slots stay zero.
   always_comb begin
      for (int unsigned lv = 0; lv < L; lv++) begin
         for (int unsigned i = 0; i < NUM_IN/2; i++) begin
            tree_d[lv][i] = '0;
         end
      end
      for (int unsigned i = 0; i < NUM_IN/2; i++) begin
         tree_d[0][i] = SW'(bus.in_data[2*i*DATAWIDTH +: DATAWIDTH])
                      + SW'(bus.in_data[(2*i+1)*DATAWIDTH +: DATAWIDTH]);
      end
      for (int unsigned lv = 1; lv < L; lv++) begin
         for (int unsigned i = 0; i < (NUM_IN >> (lv+1)); i++) begin
            tree_d[lv][i] = tree_q[lv-1][2*i] + tree_q[lv-1][2*i+1];
         end
      end

      v_d[0]    = bus.in_valid;
      mode_d[0] = bus.mode;
      rnd_d[0]  = bus.rnd;
      sa_d[0]   = bus.sa;
      for (int unsigned lv = 1; lv < L; lv++) begin
         v_d[lv]    = v_q[lv-1];
         mode_d[lv] = mode_q[lv-1];
         rnd_d[lv]  = rnd_q[lv-1];
         sa_d[lv]   = sa_q[lv-1];
      end
   end

   // Output data only reloads when a real sample arrives, so it holds after consumption.
   always_comb begin
      shift_amt   = mode_q[L-1] ? 32'(sa_q[L-1]) : L;
      ext         = {1'b0, tree_q[L-1][0]};
      rc          = '0;
      shifted     = '0;
      out_valid_d = v_q[L-1];
      sum_d       = sum_q;
      avg_d       = avg_q;
      sat_d       = sat_q;
      if (shift_amt <= SW) begin
         if (rnd_q[L-1] && (shift_amt != 0)) begin
            rc = ONE << (shift_amt - 1);
         end
         shifted = (ext + rc) >> shift_amt;
      end
      if (v_q[L-1]) begin
         sum_d = tree_q[L-1][0];
         sat_d = |shifted[SW:DATAWIDTH];
         avg_d = sat_d ? '1 : shifted[DATAWIDTH-1:0];
      end
   end

   always_ff @(posedge Clk) begin
      if (!Rst) begin
         v_q         <= '0;
         out_valid_q <= 1'b0;
         avg_q       <= '0;
         sum_q       <= '0;
         sat_q       <= 1'b0;
      end else if (en) begin
         v_q         <= v_d;
         out_valid_q <= out_valid_d;
         avg_q       <= avg_d;
         sum_q       <= sum_d;
         sat_q       <= sat_d;
      end
   end

   always_ff @(posedge Clk) begin
      if (en) begin
         tree_q <= tree_d;
         mode_q <= mode_d;
         rnd_q  <= rnd_d;
         sa_q   <= sa_d;
      end
   end
endmodule

// File: tb/tb_pipe_avg.sv
// Bench for pipe_avg (NUM_IN=8, DATAWIDTH=16): directed vectors with literal expectations
// plus an arithmetic reference model checked on every consumed result.
module tb_pipe_avg;
   typedef struct {
      longint unsigned sum;
      longint unsigned avg;
      bit              sat;
   } res_t;

   logic Clk = 1'b0;
   logic Rst = 1'b0;
   int   checks = 0;
   int   fails  = 0;
   int   n_out  = 0;
   res_t exp_q[$];

   always #5 Clk = ~Clk;

   pipe_avg_if #(.DATAWIDTH(16), .NUM_IN(8), .SAW(8)) bus ();

   pipe_avg #(.DATAWIDTH(16), .NUM_IN(8), .SAW(8)) dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (bus)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [127:0] pack_ramp(input int unsigned base, input int unsigned step);
      logic [127:0] p;
      for (int k = 0; k < 8; k++) p[k*16 +: 16] = 16'(base + step * k);
      return p;
   endfunction

   // Plain arithmetic: exact sum, divide by 2^s with optional half-up, then clip.
   function automatic res_t model(input logic [127:0] d, input logic m, input logic [7:0] s_in,
                                  input logic r);
      res_t x;
      longint unsigned s, v;
      x.sum = 0;
      for (int k = 0; k < 8; k++) x.sum += longint'(d[k*16 +: 16]);
      s = m ? longint'(s_in) : 3;
      if (s > 19) v = 0;
      else begin
         v = x.sum;
         if (r && s != 0) v += 64'd1 << (s - 1);
         v = v >> s;
      end
      x.sat = (v > 65535);
      x.avg = x.sat ? 65535 : v;
      return x;
   endfunction

   initial begin : compare
      res_t r;
      forever begin
         @(negedge Clk);
         if (Rst !== 1'b1) begin
            exp_q.delete();
         end else begin
            check("in_ready_rule", 64'(bus.in_ready), 64'(!(bus.out_valid && !bus.out_ready)));
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
               if (exp_q.size() == 0) begin
                  check("spurious_out_valid", 64'(bus.out_valid), 64'd0);
               end else begin
                  r = exp_q.pop_front();
                  check("model_sum", 64'(bus.sum), r.sum);
                  check("model_avg", 64'(bus.avg), r.avg);
                  check("model_sat", 64'(bus.sat), 64'(r.sat));
                  n_out++;
               end
            end
            if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1)
               exp_q.push_back(model(bus.in_data, bus.mode, bus.sa, bus.rnd));
         end
      end
   end

   task automatic set_in(input logic [127:0] d, input logic m, input logic [7:0] s, input logic r);
      bus.in_data = d;
      bus.mode    = m;
      bus.sa      = s;
      bus.rnd     = r;
   endtask

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send_one(input logic [127:0] d, input logic m, input logic [7:0] s, input logic r);
      bit acc = 0;
      set_in(d, m, s, r);
      bus.in_valid = 1'b1;
      for (int k = 0; k < 20 && !acc; k++) begin
         @(negedge Clk);
         acc = (bus.in_ready === 1'b1);
         @(posedge Clk); #1;
      end
      if (!acc) check("accept_timeout", 64'(bus.in_ready), 64'd1);
      bus.in_valid = 1'b0;
   endtask

   task automatic single(input string name, input logic [127:0] d, input logic m,
                         input logic [7:0] s, input logic r,
                         input longint unsigned e_sum, input longint unsigned e_avg,
                         input bit e_sat);
      int lat = 0;
      bit got = 0;
      bus.out_ready = 1'b1;
      send_one(d, m, s, r);
      for (int k = 0; k < 12 && !got; k++) begin
         @(negedge Clk);
         lat++;
         got = (bus.out_valid === 1'b1);
      end
      if (!got) check({name, "_timeout"}, 64'(bus.out_valid), 64'd1);
      else begin
         check({name, "_latency"}, 64'(lat), 64'd4);
         check({name, "_sum"}, 64'(bus.sum), e_sum);
         check({name, "_avg"}, 64'(bus.avg), e_avg);
         check({name, "_sat"}, 64'(bus.sat), 64'(e_sat));
      end
      @(posedge Clk); #1;
   endtask

   initial begin : stim
      int n, n0;
      logic [127:0] ones;
      ones = '1;

      // reset held for two edges with live inputs
      Rst = 1'b0;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b0;
      set_in(pack_ramp(9, 3), 1'b1, 8'd2, 1'b1);
      @(posedge Clk); @(posedge Clk); @(negedge Clk);
      check("reset_out_valid", 64'(bus.out_valid), 64'd0);
      check("reset_avg", 64'(bus.avg), 64'd0);
      check("reset_sum", 64'(bus.sum), 64'd0);
      check("reset_sat", 64'(bus.sat), 64'd0);
      check("reset_in_ready", 64'(bus.in_ready), 64'd1);
      @(posedge Clk); #1;
      Rst = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge Clk); #1;

      single("ramp_trunc",  pack_ramp(1, 1), 1'b0, 8'd0,  1'b0, 36, 4, 0);
      single("ramp_round",  pack_ramp(1, 1), 1'b0, 8'd0,  1'b1, 36, 5, 0);
      single("mode0_ign_sa", pack_ramp(1, 1), 1'b0, 8'd40, 1'b0, 36, 4, 0);
      single("ones_sa0",    ones,            1'b1, 8'd0,  1'b0, 524280, 65535, 1);
      single("ones_sa3",    ones,            1'b1, 8'd3,  1'b0, 524280, 65535, 0);
      single("sa40_rnd",    pack_ramp(1234, 777), 1'b1, 8'd40, 1'b1, 31628, 0, 0);
      single("sa0_rnd",     pack_ramp(1, 1), 1'b1, 8'd0,  1'b1, 36, 36, 0);
      single("half_up",     128'h1,          1'b1, 8'd1,  1'b1, 1, 1, 0);
      single("half_trunc",  128'h1,          1'b1, 8'd1,  1'b0, 1, 0, 0);
      single("ones_sa19",   ones,            1'b1, 8'd19, 1'b1, 524280, 1, 0);
      single("ones_sa20",   ones,            1'b1, 8'd20, 1'b1, 524280, 0, 0);

      // 10-sample stream with a 3-cycle downstream stall; sideband varies per sample
      n = 0;
      n0 = n_out;
      for (int c = 0; c < 30; c++) begin
         bus.out_ready = !(c >= 5 && c <= 7);
         bus.in_valid  = (n < 10);
         set_in(pack_ramp(32'(n * 100 + 1), 3), 1'(n % 2), 8'(n % 5), 1'((n / 2) % 2));
         @(negedge Clk);
         if (c < 12) check("stall_in_ready", 64'(bus.in_ready), 64'(!(c >= 5 && c <= 7)));
         if (bus.in_valid && bus.in_ready) n++;
         @(posedge Clk); #1;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      check("stream_count", 64'(n_out - n0), 64'd10);

      // three samples in flight, then a one-cycle reset
      for (int j = 0; j < 3; j++) begin
         bus.in_valid = 1'b1;
         set_in(pack_ramp(32'(500 + j), 7), 1'b0, 8'd0, 1'b0);
         @(posedge Clk); #1;
      end
      bus.in_valid = 1'b0;
      Rst = 1'b0;
      @(posedge Clk); #1;
      Rst = 1'b1;
      for (int j = 0; j < 8; j++) begin
         @(negedge Clk);
         check("flush_no_out", 64'(bus.out_valid), 64'd0);
         @(posedge Clk); #1;
      end
      single("post_reset", pack_ramp(10, 10), 1'b0, 8'd0, 1'b1, 360, 45, 0);

      // random traffic against the model
      for (int c = 0; c < 60; c++) begin
         bus.in_valid  = 1'($urandom_range(0, 1));
         bus.out_ready = ($urandom_range(0, 3) != 0);
         set_in({$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)),
                8'($urandom_range(0, 24)), 1'($urandom_range(0, 1)));
         @(posedge Clk); #1;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      repeat (10) @(posedge Clk);
      #1;
      check("drain_empty", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1);
   end
endmodule

// File: doc/pipe_avg.md
PIPE_AVG -- requirements
Module: pipe_avg

Interface
REQ-001: Parameter DATAWIDTH, default 16, SHALL set the width of each input channel and of avg.
REQ-002: Parameter NUM_IN, default 8, SHALL set the channel count; legal values are powers of two from 2 to 16.
REQ-003: Parameter SAW, default 8, SHALL set the width of sa.
REQ-004: Derived L = log2(NUM_IN) and SW = DATAWIDTH+L SHALL set the tree depth and the exact sum width.
REQ-005: Clk  input  1  rising-edge clock for all state.
REQ-006: Rst  input  1  reset; synchronous, active-low.
REQ-007: in_valid  input  1  in_data, sa, mode and rnd are valid this cycle.
REQ-008: in_ready  output  1  block accepts input this cycle.
REQ-009: in_data  input  NUM_IN*DATAWIDTH  packed unsigned channels; channel k occupies bits [k*DATAWIDTH +: DATAWIDTH].
REQ-010: sa  input  SAW  shift amount used in mode 1.
REQ-011: mode  input  1  0 = divide by NUM_IN; 1 = shift right by sa.
REQ-012: rnd  input  1  1 = round half-up before the shift; 0 = truncate.
REQ-013: out_valid  output  1  avg, sum and sat hold a result.
REQ-014: out_ready  input  1  downstream accepts the result.
REQ-015: avg  output  DATAWIDTH  shifted, saturated result.
REQ-016: sum  output  SW  unshifted exact sum for the same sample.
REQ-017: sat  output  1  avg was clipped this result.

Function
REQ-018: Inputs SHALL be zero-extended to SW bits; the sum SHALL never overflow.
REQ-019: The adder tree SHALL have L pipeline stages, with one register per level halving the operand count.
REQ-020: A final stage SHALL register the shift, round and saturate result; latency is L+1 cycles from acceptance to out_valid when unstalled (4 cycles at NUM_IN=8).
REQ-021: sa, mode and rnd SHALL be captured at acceptance and travel with the sample; later changes SHALL not affect samples in flight.
REQ-022: Effective shift s SHALL be L when mode=0 and sa when mode=1.
REQ-023: When rnd=1 and s>0, the block SHALL add 2^(s-1) before shifting, using SW+1 bits so the addition never wraps; s=0 SHALL not round.
REQ-024: s >= SW+1 SHALL yield a shifted value of 0 with no X or wrap; the rounding constant SHALL then also give 0.
REQ-025: A shifted value above 2^DATAWIDTH-1 SHALL drive avg to all-ones and set sat=1; otherwise sat=0.
REQ-026: in_ready SHALL equal NOT(out_valid AND NOT out_ready), combinationally.
REQ-027: A sample SHALL be accepted only when in_valid AND in_ready are both high.
REQ-028: While in_ready=0, every pipeline stage and all outputs SHALL hold their values; no sample SHALL be lost or duplicated.
REQ-029: Stage valid bits SHALL propagate so bubbles (in_valid=0) pass through without producing out_valid.
REQ-030: A result SHALL be consumed on a cycle where out_valid=1 and out_ready=1; on the same edge the next stage's contents SHALL load, so back-to-back throughput is one sample per cycle.
REQ-031: With out_ready held high, the block SHALL accept and emit one sample per clock indefinitely.

Reset
REQ-032: When Rst=0 at a rising Clk, the block SHALL clear every stage valid bit, and set out_valid=0, avg=0, sum=0 and sat=0.
REQ-033: in_ready SHALL read 1 during and after reset.
REQ-034: Reset mid-operation SHALL discard all in-flight samples; no result from before the reset SHALL appear afterwards.
REQ-035: Data registers other than the outputs need not be cleared.

Verification (NUM_IN=8, DATAWIDTH=16)
REQ-036: Hold Rst=0 for 2 cycles with arbitrary inputs -> out_valid=0, avg=0, sum=0, sat=0, in_ready=1.
REQ-037: Apply channels 1..8, mode=0, rnd=0 at cycle t -> at cycle t+4: out_valid=1, sum=36, avg=4, sat=0; the same sample with rnd=1 -> avg=5.
REQ-038: Apply all channels 0xFFFF, mode=1, sa=0 -> sum=524280, avg=0xFFFF, sat=1; the same sample with sa=3 -> avg=0xFFFF, sat=0.
REQ-039: Stream 10 consecutive samples with out_ready low for 3 cycles mid-stream -> in_ready low exactly during the stall, all 10 results in order, none duplicated.
REQ-040: Apply mode=1, sa=40, rnd=1, any data -> avg=0, sat=0, and sum equals the exact sum.
REQ-041: Assert Rst=0 for one cycle while 3 samples are in flight -> no out_valid for those samples; a fresh sample afterwards appears after 4 cycles with correct values.
